// File: rtl/seq_detect_if.sv
// Bus bundle between the serial requesters / config master and the shared
// pattern-detector scheduler.
interface seq_detect_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned PAT_W  = 4
);
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] din;
   logic [NUM_CH-1:0] gnt;
   logic              cfg_valid;
   logic [PAT_W-1:0]  cfg_pattern;
   logic              cfg_ready;
   logic              match_valid;
   logic [CH_W-1:0]   match_ch;
   logic [15:0]       match_count;

   modport master (
      output req, din, cfg_valid, cfg_pattern,
      input  gnt, cfg_ready, match_valid, match_ch, match_count
   );

   modport slave (
      input  req, din, cfg_valid, cfg_pattern,
      output gnt, cfg_ready, match_valid, match_ch, match_count
   );
endinterface

// File: rtl/seq_detect_scheduler.sv
// One programmable serial-pattern detector time-shared among NUM_CH bit-serial
// requesters by a round-robin arbiter; each channel keeps a private history.
module seq_detect_scheduler #(
   parameter int unsigned      NUM_CH      = 4,
   parameter int unsigned      PAT_W       = 4,
   parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b1010)
) (
   input  logic        clk,
   input  logic        reset,
   seq_detect_if.slave bus
);
   localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned FILL_W = $clog2(PAT_W + 1);
   localparam int unsigned CNT_W  = 16;

   typedef enum logic {
      ST_RUN = 1'b0,
      ST_CFG = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [CH_W-1:0]    ptr_q, ptr_d;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic [PAT_W-1:0]   hist_q [NUM_CH];
   logic [PAT_W-1:0]   hist_d [NUM_CH];
   logic [FILL_W-1:0]  fill_q [NUM_CH];
   logic [FILL_W-1:0]  fill_d [NUM_CH];
   logic               match_valid_q, match_valid_d;
   logic [CH_W-1:0]    match_ch_q, match_ch_d;
   logic [CNT_W-1:0]   match_count_q, match_count_d;

   logic [NUM_CH-1:0]  gnt_c;
   logic               cfg_ready_c;
   logic               found_c;
   logic [CH_W-1:0]    sel_c;
   logic [CH_W-1:0]    cand_c;
   logic [PAT_W-1:0]   shifted_c;
   logic               hit_c;

   // Round-robin search: first requester at or after ptr, wrapping around.
   always_comb begin
      found_c = 1'b0;
      sel_c   = '0;
      cand_c  = '0;
      for (int unsigned off = 0; off < NUM_CH; off++) begin
         cand_c = CH_W'((32'(ptr_q) + off) % NUM_CH);
         if (!found_c && bus.req[cand_c]) begin
            found_c = 1'b1;
            sel_c   = cand_c;
         end
      end
   end

   // Next-state, grant/ready outputs and datapath updates for the granted channel.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      pat_d         = pat_q;
      hist_d        = hist_q;
      fill_d        = fill_q;
      match_valid_d = 1'b0;
      match_ch_d    = match_ch_q;
      match_count_d = match_count_q;
      gnt_c         = '0;
      cfg_ready_c   = 1'b0;
      shifted_c     = {hist_q[sel_c][PAT_W-2:0], bus.din[sel_c]};
      hit_c         = 1'b0;

      if (!reset) begin
         case (state_q)
            ST_RUN: begin
               cfg_ready_c = 1'b1;
               if (bus.cfg_valid) begin
                  // Config wins over requests: no grant, wipe all channel state.
                  state_d       = ST_CFG;
                  pat_d         = bus.cfg_pattern;
                  match_count_d = '0;
                  for (int i = 0; i < NUM_CH; i++) begin
                     hist_d[i] = '0;
                     fill_d[i] = '0;
                  end
               end else if (found_c) begin
                  gnt_c[sel_c] = 1'b1;
                  ptr_d        = (sel_c == CH_W'(NUM_CH - 1)) ? '0 : sel_c + CH_W'(1);
                  hist_d[sel_c] = shifted_c;
                  if (fill_q[sel_c] != FILL_W'(PAT_W)) begin
                     fill_d[sel_c] = fill_q[sel_c] + FILL_W'(1);
                  end
                  // Fill guard: a match needs PAT_W real bits, counting this one.
                  hit_c = (shifted_c == pat_q) && (fill_q[sel_c] >= FILL_W'(PAT_W - 1));
                  if (hit_c) begin
                     match_valid_d = 1'b1;
                     match_ch_d    = sel_c;
                     if (match_count_q != {CNT_W{1'b1}}) begin
                        match_count_d = match_count_q + CNT_W'(1);
                     end
                  end
               end
            end
            ST_CFG: begin
               state_d = ST_RUN;
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers: pointer, pattern, per-channel history/fill, match reporting.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q         <= '0;
         pat_q         <= DEFAULT_PAT;
         for (int i = 0; i < NUM_CH; i++) begin
            hist_q[i] <= '0;
            fill_q[i] <= '0;
         end
         match_valid_q <= 1'b0;
         match_ch_q    <= '0;
         match_count_q <= '0;
      end else begin
         ptr_q         <= ptr_d;
         pat_q         <= pat_d;
         hist_q        <= hist_d;
         fill_q        <= fill_d;
         match_valid_q <= match_valid_d;
         match_ch_q    <= match_ch_d;
         match_count_q <= match_count_d;
      end
   end

   assign bus.gnt         = gnt_c;
   assign bus.cfg_ready   = cfg_ready_c;
   assign bus.match_valid = match_valid_q;
   assign bus.match_ch    = match_ch_q;
   assign bus.match_count = match_count_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Bench for seq_detect_scheduler: directed table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_seq_detect_scheduler;
   localparam int unsigned NUM_CH = 4;
   localparam int unsigned PAT_W  = 4;
   localparam int unsigned CH_W   = 2;

   logic clk = 1'b0;
   logic reset;

   seq_detect_if #(.NUM_CH(NUM_CH), .PAT_W(PAT_W)) bus ();

   seq_detect_scheduler #(
      .NUM_CH      (NUM_CH),
      .PAT_W       (PAT_W),
      .DEFAULT_PAT (4'b1010)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state: each channel keeps the list of its last PAT_W real bits.
   int               m_ptr;
   logic [PAT_W-1:0] m_pat;
   bit               m_cfg;
   bit               m_hist [NUM_CH][$];
   bit               m_mv;
   int               m_mch;
   int               m_cnt;

   typedef struct packed {
      bit              rst;
      logic [3:0]      req;
      logic [3:0]      din;
      bit              cv;
      logic [3:0]      gnt;
      bit              mv;
      logic [CH_W-1:0] mch;
      logic [15:0]     cnt;
   } vec_t;

   vec_t tbl [$];
   bit   pat_seq [4];

   function automatic vec_t mk(bit rst, logic [3:0] req, logic [3:0] din, bit cv,
                               logic [3:0] gnt, bit mv, logic [CH_W-1:0] mch, logic [15:0] cnt);
      vec_t v;
      v.rst = rst; v.req = req; v.din = din; v.cv = cv;
      v.gnt = gnt; v.mv = mv; v.mch = mch; v.cnt = cnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // True when the channel's most recent PAT_W real bits spell the pattern (oldest = MSB).
   function automatic bit window_matches(int ch);
      logic [PAT_W-1:0] w;
      if (m_hist[ch].size() != PAT_W) return 1'b0;
      w = '0;
      for (int i = 0; i < PAT_W; i++) w[PAT_W-1-i] = m_hist[ch][i];
      return w == m_pat;
   endfunction

   // One clock: drive inputs, check combinational outputs, step model, check registered outputs.
   task automatic cyc(input bit r, input logic [NUM_CH-1:0] rq, input logic [NUM_CH-1:0] dn,
                      input bit cv, input logic [PAT_W-1:0] cp, input bit do_chk,
                      output logic [NUM_CH-1:0] g_obs);
      logic [NUM_CH-1:0] eg;
      bit                er;
      int                k;
      reset           = r;
      bus.req         = rq;
      bus.din         = dn;
      bus.cfg_valid   = cv;
      bus.cfg_pattern = cp;
      #1;
      eg = '0;
      er = 1'b0;
      k  = -1;
      if (!r && !m_cfg) begin
         er = 1'b1;
         if (!cv) begin
            for (int off = 0; off < NUM_CH; off++) begin
               int c;
               c = (m_ptr + off) % NUM_CH;
               if (k < 0 && rq[c]) k = c;
            end
         end
         if (k >= 0) eg[k] = 1'b1;
      end
      g_obs = bus.gnt;
      if (do_chk) begin
         check("gnt", 32'(bus.gnt), 32'(eg));
         check("cfg_ready", 32'(bus.cfg_ready), 32'(er));
      end
      if (r) begin
         m_ptr = 0; m_pat = 4'b1010; m_cfg = 1'b0; m_mv = 1'b0; m_mch = 0; m_cnt = 0;
         for (int i = 0; i < NUM_CH; i++) m_hist[i].delete();
      end else if (m_cfg) begin
         m_cfg = 1'b0;
         m_mv  = 1'b0;
      end else if (cv) begin
         m_cfg = 1'b1; m_pat = cp; m_cnt = 0; m_mv = 1'b0;
         for (int i = 0; i < NUM_CH; i++) m_hist[i].delete();
      end else if (k >= 0) begin
         m_hist[k].push_back(bit'(dn[k]));
         if (m_hist[k].size() > PAT_W) void'(m_hist[k].pop_front());
         m_ptr = (k + 1) % NUM_CH;
         m_mv  = window_matches(k);
         if (m_mv) begin
            m_mch = k;
            if (m_cnt < 65535) m_cnt++;
         end
      end else begin
         m_mv = 1'b0;
      end
      @(posedge clk);
      #1;
      if (do_chk) begin
         check("match_valid", 32'(bus.match_valid), 32'(m_mv));
         check("match_ch", 32'(bus.match_ch), 32'(m_mch));
         check("match_count", 32'(bus.match_count), 32'(m_cnt));
      end
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NUM_CH-1:0] g;
      logic [NUM_CH-1:0] dn;
      int                i1;
      int                i2;
      bit                r;
      bit                cv;
      logic [PAT_W-1:0]  cp;

      pat_seq = '{1'b1, 1'b0, 1'b1, 1'b0};

      // ---- Directed table: reset, single channel with overlap, fairness ----
      tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 16'd0));
      tbl.push_back(mk(0, 4'b0001, 4'b0001, 0, 4'b0001, 0, 0, 16'd0));
      tbl.push_back(mk(0, 4'b0001, 4'b0000, 0, 4'b0001, 0, 0, 16'd0));
      tbl.push_back(mk(0, 4'b0001, 4'b0001, 0, 4'b0001, 0, 0, 16'd0));
      tbl.push_back(mk(0, 4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 16'd1));
      tbl.push_back(mk(0, 4'b0001, 4'b0001, 0, 4'b0001, 0, 0, 16'd1));
      tbl.push_back(mk(0, 4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 16'd2));
      tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 16'd0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 4'b0001, 0, 0, 16'd0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 4'b0010, 0, 0, 16'd0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 4'b0100, 0, 0, 16'd0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 4'b1000, 0, 0, 16'd0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 4'b0001, 0, 0, 16'd0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 4'b0010, 0, 0, 16'd0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 4'b0100, 0, 0, 16'd0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 4'b1000, 0, 0, 16'd0));
      tbl.push_back(mk(0, 4'b1010, 4'b0000, 0, 4'b0010, 0, 0, 16'd0));
      tbl.push_back(mk(0, 4'b1010, 4'b0000, 0, 4'b1000, 0, 0, 16'd0));
      tbl.push_back(mk(0, 4'b1010, 4'b0000, 0, 4'b0010, 0, 0, 16'd0));

      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].rst, tbl[i].req, tbl[i].din, tbl[i].cv, 4'b0000, 1'b1, g);
         check($sformatf("tbl%0d_gnt", i), 32'(g), 32'(tbl[i].gnt));
         check($sformatf("tbl%0d_mv", i), 32'(bus.match_valid), 32'(tbl[i].mv));
         check($sformatf("tbl%0d_mch", i), 32'(bus.match_ch), 32'(tbl[i].mch));
         check($sformatf("tbl%0d_cnt", i), 32'(bus.match_count), 32'(tbl[i].cnt));
      end

      // ---- Interleaved history: ch1 and ch2 each send 1,0,1,0 ----
      cyc(1, '0, '0, 0, '0, 1'b1, g);
      i1 = 0;
      i2 = 0;
      for (int c = 0; c < 8; c++) begin
         dn    = '0;
         dn[1] = pat_seq[i1];
         dn[2] = pat_seq[i2];
         cyc(0, 4'b0110, dn, 0, '0, 1'b1, g);
         if (g[1]) i1++;
         if (g[2]) i2++;
         if (c == 6) begin
            check("ilv_mv_ch1", 32'(bus.match_valid), 32'd1);
            check("ilv_mch_ch1", 32'(bus.match_ch), 32'd1);
         end
      end
      check("ilv_mv_ch2", 32'(bus.match_valid), 32'd1);
      check("ilv_mch_ch2", 32'(bus.match_ch), 32'd2);
      check("ilv_cnt", 32'(bus.match_count), 32'd2);

      // ---- Fill guard: pattern 0000 needs four real zeros on ch3 ----
      cyc(0, '0, '0, 1, 4'b0000, 1'b1, g);
      cyc(0, '0, '0, 0, '0, 1'b1, g);
      for (int c = 0; c < 3; c++) begin
         cyc(0, 4'b1000, 4'b0000, 0, '0, 1'b1, g);
         check("fill_no_match", 32'(bus.match_valid), 32'd0);
      end
      cyc(0, 4'b1000, 4'b0000, 0, '0, 1'b1, g);
      check("fill_mv", 32'(bus.match_valid), 32'd1);
      check("fill_mch", 32'(bus.match_ch), 32'd3);

      // ---- Config collision with all channels requesting ----
      for (int c = 0; c < 3; c++) cyc(0, 4'b1111, 4'b1111, 0, '0, 1'b1, g);
      cyc(0, 4'b1111, 4'b1111, 1, 4'b1010, 1'b1, g);
      check("col_gnt_accept", 32'(g), 32'd0);
      check("col_cnt_clear", 32'(bus.match_count), 32'd0);
      check("col_ready_cfg", 32'(bus.cfg_ready), 32'd0);
      cyc(0, 4'b1111, 4'b1111, 0, '0, 1'b1, g);
      check("col_gnt_cfg", 32'(g), 32'd0);
      cyc(0, 4'b1111, 4'b0000, 0, '0, 1'b1, g);
      check("col_resume_ptr", 32'(g), 32'b1000);
      // ch0 held a stale 1 before the config; 0,1,0 must not complete 1010
      for (int c = 0; c < 3; c++) begin
         dn = (c == 1) ? 4'b0001 : 4'b0000;
         cyc(0, 4'b0001, dn, 0, '0, 1'b1, g);
         check("col_hist_cleared", 32'(bus.match_valid), 32'd0);
      end

      // ---- Match in N reported in N+1 while a config is accepted ----
      cyc(0, 4'b0001, 4'b0001, 0, '0, 1'b1, g);
      cyc(0, 4'b0001, 4'b0000, 0, '0, 1'b1, g);
      check("late_mv", 32'(bus.match_valid), 32'd1);
      check("late_cnt", 32'(bus.match_count), 32'd1);
      cyc(0, 4'b0001, 4'b0000, 1, 4'b1010, 1'b1, g);
      check("late_cnt_clear", 32'(bus.match_count), 32'd0);
      cyc(0, '0, '0, 0, '0, 1'b1, g);

      // ---- Randomized traffic against the model ----
      for (int c = 0; c < 3000; c++) begin
         r  = ($urandom_range(0, 499) == 0);
         cv = ($urandom_range(0, 29) == 0);
         cp = ($urandom_range(0, 2) == 0) ? 4'b1010 : PAT_W'($urandom);
         cyc(r, NUM_CH'($urandom), NUM_CH'($urandom), cv, cp, 1'b1, g);
      end

      // ---- Saturation: pattern 0000, all channels streaming zeros ----
      cyc(0, '0, '0, 1, 4'b0000, 1'b1, g);
      cyc(0, '0, '0, 0, '0, 1'b1, g);
      for (int c = 0; c < 65560; c++) cyc(0, 4'b1111, 4'b0000, 0, '0, 1'b0, g);
      cyc(0, 4'b1111, 4'b0000, 0, '0, 1'b1, g);
      check("sat_cnt", 32'(bus.match_count), 32'h0000_FFFF);
      check("sat_mv", 32'(bus.match_valid), 32'd1);

      // ---- Reset mid-pattern, then four fresh bits under the default pattern ----
      cyc(0, 4'b0001, 4'b0001, 0, '0, 1'b1, g);
      cyc(0, 4'b0001, 4'b0000, 0, '0, 1'b1, g);
      cyc(1, 4'b0001, 4'b0001, 0, '0, 1'b1, g);
      check("rst_mv", 32'(bus.match_valid), 32'd0);
      check("rst_mch", 32'(bus.match_ch), 32'd0);
      check("rst_cnt", 32'(bus.match_count), 32'd0);
      for (int c = 0; c < 3; c++) begin
         dn = pat_seq[c] ? 4'b0001 : 4'b0000;
         cyc(0, 4'b0001, dn, 0, '0, 1'b1, g);
         check("rst_fresh_no_match", 32'(bus.match_valid), 32'd0);
      end
      cyc(0, 4'b0001, 4'b0000, 0, '0, 1'b1, g);
      check("rst_fresh_mv", 32'(bus.match_valid), 32'd1);
      check("rst_fresh_cnt", 32'(bus.match_count), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
